// File: rtl/temp_mon_pkg.sv
// Shared types and widths for the temperature-monitor datapath.
// Used by the averaging divider and its bus interface.
package temp_mon_pkg;

   localparam int TEMP_SUM_W = 16;
   localparam int SENS_NR_W  = 8;
   localparam int RESULT_W   = 16;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

endpackage

// File: rtl/temp_avg_divider_if.sv
// Request/result bundle between the sensor accumulator and the averaging divider.
// The slave side is the divider; the master side issues requests and reads results.
interface temp_avg_divider_if
   import temp_mon_pkg::*;
#(
   parameter int DIVIDEND_W = TEMP_SUM_W,
   parameter int DIVISOR_W  = SENS_NR_W
);

   logic                  start_i;
   logic [DIVIDEND_W-1:0] temp_sum_i;
   logic [DIVISOR_W-1:0]  active_sensors_nr_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  div_zero_o;
   logic [RESULT_W-1:0]   temp_Q_o;
   logic [RESULT_W-1:0]   temp_R_o;
   logic [DIVISOR_W-1:0]  active_sensors_nr_o;

   modport master (
      output start_i, temp_sum_i, active_sensors_nr_i,
      input  busy_o, done_o, div_zero_o, temp_Q_o, temp_R_o, active_sensors_nr_o
   );

   modport slave (
      input  start_i, temp_sum_i, active_sensors_nr_i,
      output busy_o, done_o, div_zero_o, temp_Q_o, temp_R_o, active_sensors_nr_o
   );

endinterface

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_restore_step #(
   parameter int DIVISOR_W = 8
) (
   input  logic [DIVISOR_W:0]   rem,
   input  logic                 dividend_bit,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   rem_next,
   output logic                 quot_bit
);

   logic [DIVISOR_W+1:0] trial;

   // The trial value is kept one bit wider than the remainder so the compare never wraps.
   always_comb begin
      trial    = {rem, dividend_bit};
      quot_bit = (trial >= {2'b00, divisor});
      rem_next = quot_bit ? (DIVISOR_W+1)'(trial - {2'b00, divisor})
                          : (DIVISOR_W+1)'(trial);
   end

endmodule

// File: rtl/temp_avg_divider.sv
// Sequential restoring divider: average temperature = sum / active sensor count,
// one quotient bit per clock, results held stable for the display/alert stage.
module temp_avg_divider
   import temp_mon_pkg::*;
#(
   parameter int DIVIDEND_W = TEMP_SUM_W,
   parameter int DIVISOR_W  = SENS_NR_W
) (
   input logic               clk_i,
   input logic               rst_n_i,
   temp_avg_divider_if.slave bus
);

   localparam int ITER_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DIVIDEND_W - 1);

   div_state_t            state_q;
   logic [DIVIDEND_W-1:0] dq_q;
   logic [DIVISOR_W-1:0]  divisor_q;
   logic [DIVISOR_W:0]    rem_q;
   logic [ITER_W-1:0]     iter_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  div_zero_q;
   logic [RESULT_W-1:0]   quot_out_q;
   logic [RESULT_W-1:0]   rem_out_q;
   logic [DIVISOR_W-1:0]  nr_out_q;

   logic [DIVISOR_W:0]    rem_nxt;
   logic                  quot_bit;
   logic [DIVIDEND_W-1:0] dq_nxt;

   function automatic logic [RESULT_W-1:0] fit_quot(input logic [DIVIDEND_W-1:0] q);
      return RESULT_W'(q);
   endfunction

   function automatic logic [RESULT_W-1:0] fit_rem(input logic [DIVISOR_W:0] r);
      return RESULT_W'(r);
   endfunction

   div_restore_step #(.DIVISOR_W(DIVISOR_W)) u_step (
      .rem          (rem_q),
      .dividend_bit (dq_q[DIVIDEND_W-1]),
      .divisor      (divisor_q),
      .rem_next     (rem_nxt),
      .quot_bit     (quot_bit)
   );

   // Dividend bits leave at the top while quotient bits enter at the bottom of the same register.
   assign dq_nxt = {dq_q[DIVIDEND_W-2:0], quot_bit};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         dq_q       <= '0;
         divisor_q  <= '0;
         rem_q      <= '0;
         iter_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         quot_out_q <= '0;
         rem_out_q  <= '0;
         nr_out_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start_i) begin
                  dq_q      <= bus.temp_sum_i;
                  divisor_q <= bus.active_sensors_nr_i;
                  rem_q     <= '0;
                  iter_q    <= ITER_LAST;
                  busy_q    <= 1'b1;
                  if (bus.active_sensors_nr_i == '0) begin
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                     div_zero_q <= 1'b1;
                     quot_out_q <= '0;
                     rem_out_q  <= '0;
                     nr_out_q   <= '0;
                  end else begin
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               dq_q  <= dq_nxt;
               rem_q <= rem_nxt;
               if (iter_q == '0) begin
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  div_zero_q <= 1'b0;
                  quot_out_q <= fit_quot(dq_nxt);
                  rem_out_q  <= fit_rem(rem_nxt);
                  nr_out_q   <= divisor_q;
               end else begin
                  iter_q <= iter_q - 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy_o              = busy_q;
   assign bus.done_o              = done_q;
   assign bus.div_zero_o          = div_zero_q;
   assign bus.temp_Q_o            = quot_out_q;
   assign bus.temp_R_o            = rem_out_q;
   assign bus.active_sensors_nr_o = nr_out_q;

endmodule

// File: tb/tb_temp_avg_divider.sv
// Bench for temp_avg_divider: directed cases plus randomized requests checked
// against plain integer division, including latency, hold and reset behaviour.
module tb_temp_avg_divider;
   import temp_mon_pkg::*;

   localparam int DW = TEMP_SUM_W;
   localparam int SW = SENS_NR_W;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] exp_q  = '0;
   logic [31:0] exp_r  = '0;
   logic [31:0] exp_dz = '0;
   logic [31:0] exp_nr = '0;

   temp_avg_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) bus ();

   temp_avg_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_held(input string tag);
      chk({tag, "_q"},  32'(bus.temp_Q_o), exp_q);
      chk({tag, "_r"},  32'(bus.temp_R_o), exp_r);
      chk({tag, "_dz"}, 32'(bus.div_zero_o), exp_dz);
      chk({tag, "_nr"}, 32'(bus.active_sensors_nr_o), exp_nr);
   endtask

   // Issue one request and follow it to the cycle after done_o; inject_at > 0 raises
   // start_i with other operands in that cycle of the transaction.
   task automatic run_div(input logic [15:0] sum, input logic [7:0] nr, input int inject_at);
      int  k;
      int  lat;
      bit  seen;
      bus.start_i             = 1'b1;
      bus.temp_sum_i          = sum;
      bus.active_sensors_nr_i = nr;
      lat = (nr == 8'd0) ? 1 : DW + 1;
      step();
      bus.start_i             = 1'b0;
      bus.temp_sum_i          = 16'($urandom);
      bus.active_sensors_nr_i = 8'($urandom);
      k    = 1;
      seen = 1'b0;
      while (!seen && k <= DW + 8) begin
         if (k == inject_at) begin
            bus.start_i             = 1'b1;
            bus.temp_sum_i          = 16'(90 + $urandom_range(0, 50));
            bus.active_sensors_nr_i = 8'($urandom_range(0, 9));
         end
         if (bus.done_o === 1'b1) begin
            seen = 1'b1;
         end else begin
            chk("busy_calc", 32'(bus.busy_o), 32'd1);
            if (k == 1) chk_held("hold_calc");
            step();
            bus.start_i = 1'b0;
            k++;
         end
      end
      if (!seen) begin
         chk("done_timeout", 32'd0, 32'd1);
      end else begin
         if (nr == 8'd0) begin
            exp_q = '0; exp_r = '0; exp_dz = 32'd1; exp_nr = '0;
         end else begin
            exp_q  = 32'(sum) / 32'(nr);
            exp_r  = 32'(sum) % 32'(nr);
            exp_dz = '0;
            exp_nr = 32'(nr);
         end
         chk("latency", 32'(k), 32'(lat));
         chk("busy_done", 32'(bus.busy_o), 32'd1);
         chk_held("result");
      end
      step();
      bus.start_i = 1'b0;
      chk("done_pulse", 32'(bus.done_o), 32'd0);
      chk("busy_idle", 32'(bus.busy_o), 32'd0);
      chk_held("hold_idle");
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         bus.temp_sum_i          = 16'($urandom);
         bus.active_sensors_nr_i = 8'($urandom);
         step();
         chk("gap_done", 32'(bus.done_o), 32'd0);
         chk_held("gap");
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
      $fatal(1);
   end

   initial begin
      logic [15:0] rs;
      logic [7:0]  rn;
      int          sel;
      int          inj;
      bus.start_i             = 1'b0;
      bus.temp_sum_i          = '0;
      bus.active_sensors_nr_i = '0;
      #1;
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_done", 32'(bus.done_o), 32'd0);
      chk_held("rst");
      #22;
      @(negedge clk);
      rst_n = 1'b1;
      step();

      run_div(16'd200, 8'd8, 0);
      run_div(16'd211, 8'd8, 0);
      run_div(16'd0, 8'd5, 0);
      run_div(16'd150, 8'd0, 0);
      run_div(16'd77, 8'd4, 0);
      run_div(16'hFFFF, 8'd255, 0);
      run_div(16'hFFFF, 8'd1, 0);
      run_div(16'd100, 8'd7, 5);
      run_div(16'd5, 8'd9, 0);

      // Reset in the middle of a calculation with a nonzero result on the outputs.
      bus.start_i             = 1'b1;
      bus.temp_sum_i          = 16'd100;
      bus.active_sensors_nr_i = 8'd7;
      step();
      bus.start_i = 1'b0;
      repeat (7) step();
      #2 rst_n = 1'b0;
      #1;
      exp_q = '0; exp_r = '0; exp_dz = '0; exp_nr = '0;
      chk("midrst_busy", 32'(bus.busy_o), 32'd0);
      chk("midrst_done", 32'(bus.done_o), 32'd0);
      chk_held("midrst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < DW + 3; i++) begin
         step();
         chk("postrst_done", 32'(bus.done_o), 32'd0);
         chk("postrst_busy", 32'(bus.busy_o), 32'd0);
      end
      chk_held("postrst");
      run_div(16'd1234, 8'd10, 0);

      for (int t = 0; t < 40; t++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       rn = 8'd0;
            1:       rn = 8'd1;
            2:       rn = 8'd255;
            default: rn = 8'($urandom_range(1, 255));
         endcase
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       rs = 16'hFFFF;
            1:       rs = 16'd0;
            default: rs = 16'($urandom);
         endcase
         inj = 0;
         if (rn != 8'd0 && $urandom_range(0, 3) == 0) inj = int'($urandom_range(1, DW + 1));
         run_div(rs, rn, inj);
         idle_gap(int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
